// File: rtl/hw_input_stream_feeder_if.sv
// rtl/hw_input_stream_feeder_if.sv - upstream stream and accelerator pull-port bundle for the input feeder
interface hw_input_stream_feeder_if #(
  parameter int DATA_W = 16
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              hw_read_en;
  logic [DATA_W-1:0] hw_read;

  // slave is the feeder side; master is the upstream source plus accelerator
  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    input  hw_read_en,
    output hw_read
  );

  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    output hw_read_en,
    input  hw_read
  );
endinterface

// File: rtl/hw_input_stream_feeder.sv
// rtl/hw_input_stream_feeder.sv - FWFT pixel FIFO with frame counter; optional sticky underrun flag under HW_FEEDER_UNDERRUN_CHECK_EN
module hw_input_stream_feeder #(
  parameter int DATA_W       = 16,
  parameter int DEPTH        = 16,
  parameter int FRAME_PIXELS = 4096
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  hw_input_stream_feeder_if.slave bus,
  output logic [$clog2(DEPTH):0] level,
  output logic                   frame_done,
  output logic                   underrun
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = AW + 1;
  localparam int PIX_W = (FRAME_PIXELS > 1) ? $clog2(FRAME_PIXELS) : 1;
  localparam logic [PIX_W-1:0] LAST_PIX = PIX_W'(FRAME_PIXELS - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_rd_ptr;
  logic [AW-1:0]     r_wr_ptr;
  logic [CW-1:0]     r_count;
  state_t            r_state;
  logic [PIX_W-1:0]  r_pix_cnt;
  logic              r_frame_done;

  logic w_empty;
  logic w_full;
  logic w_push;
  logic w_pop;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CW'(DEPTH));

  // No full bypass: a pop in the same cycle does not open a slot for a push.
  assign bus.in_ready = rst_n && !flush && !w_full;
  assign w_push       = bus.in_valid && bus.in_ready;
  assign w_pop        = bus.hw_read_en && !w_empty && !flush;

  assign bus.hw_read = w_empty ? '0 : r_mem[r_rd_ptr];
  assign level       = r_count;
  assign frame_done  = r_frame_done;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= bus.in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // IDLE and DONE both hold pix_cnt at 0, so any pop there is pixel 0 of a frame.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      r_state      <= S_IDLE;
      r_pix_cnt    <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      if (w_pop) begin
        if (r_pix_cnt == LAST_PIX) begin
          r_state      <= S_DONE;
          r_pix_cnt    <= '0;
          r_frame_done <= 1'b1;
        end else begin
          r_state   <= S_ACTIVE;
          r_pix_cnt <= r_pix_cnt + PIX_W'(1);
        end
      end else if (r_state == S_DONE) begin
        r_state <= S_IDLE;
      end
    end
  end

`ifdef HW_FEEDER_UNDERRUN_CHECK_EN
  logic w_rd_empty;
  logic r_underrun;

  assign w_rd_empty = bus.hw_read_en && w_empty;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_underrun <= 1'b0;
    end else if (w_rd_empty) begin
      r_underrun <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && w_rd_empty) begin
      $error("hw_input_stream_feeder: read requested on empty FIFO");
    end
  end

  assign underrun = r_underrun;
`else
  assign underrun = 1'b0;
`endif

endmodule

// File: tb/tb_hw_input_stream_feeder.sv
// tb/tb_hw_input_stream_feeder.sv - randomized queue-model bench for hw_input_stream_feeder
module tb_hw_input_stream_feeder;
  localparam int DW = 16;
  localparam int DP = 16;
  localparam int FP = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic [4:0]  level;
  logic        frame_done;
  logic        underrun;

  hw_input_stream_feeder_if #(.DATA_W(DW)) bus ();

  hw_input_stream_feeder #(.DATA_W(DW), .DEPTH(DP), .FRAME_PIXELS(FP)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .bus        (bus),
    .level      (level),
    .frame_done (frame_done),
    .underrun   (underrun)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] q[$];
  int          m_pops = 0;
  bit          m_fd = 1'b0;
  bit          m_ur = 1'b0;
  int          fd_seen;
  int          cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called just after a negedge: drive, check outputs, advance model across the next posedge.
  task automatic cycle(input bit v, input logic [15:0] d, input bit re, input bit fl);
    bit exp_ready;
    bit push;
    bit pop;
    bus.in_valid   = v;
    bus.in_data    = d;
    bus.hw_read_en = re;
    flush          = fl;
    #1;
    exp_ready = !fl && (q.size() < DP);
    chk("in_ready", 32'(bus.in_ready), 32'(exp_ready));
    chk("hw_read", 32'(bus.hw_read), (q.size() != 0) ? 32'(q[0]) : 32'd0);
    chk("level", 32'(level), 32'(q.size()));
    chk("frame_done", 32'(frame_done), 32'(m_fd));
    chk("underrun", 32'(underrun), 32'(m_ur));
    push = v && exp_ready;
    pop  = re && (q.size() != 0) && !fl;
`ifdef HW_FEEDER_UNDERRUN_CHECK_EN
    if (re && q.size() == 0) m_ur = 1'b1;
`endif
    if (fl) begin
      q.delete();
      m_pops = 0;
      m_fd   = 1'b0;
    end else begin
      m_fd = 1'b0;
      if (pop) begin
        void'(q.pop_front());
        m_pops++;
        if (m_pops == FP) begin
          m_fd   = 1'b1;
          m_pops = 0;
        end
      end
      if (push) q.push_back(d);
    end
    @(negedge clk);
  endtask

  initial begin
    rst_n          = 1'b0;
    flush          = 1'b0;
    bus.in_valid   = 1'b0;
    bus.in_data    = '0;
    bus.hw_read_en = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_hw_read", 32'(bus.hw_read), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_underrun", 32'(underrun), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);

    // ordered fill then drain
    for (int i = 0; i < 16; i++) cycle(1'b1, 16'(i), 1'b0, 1'b0);
    chk("full_level", 32'(level), 32'd16);
    cycle(1'b1, 16'h0099, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b1);

    // concurrent traffic, counter data
    cnt = 0;
    fd_seen = 0;
    for (int i = 0; i < 41; i++) begin
      cycle(1'b1, 16'(cnt), 1'b1, 1'b0);
      cnt++;
      if (frame_done) fd_seen++;
    end
    chk("concurrent_fd_count", 32'(fd_seen), 32'd5);
    while (q.size() != 0) cycle(1'b0, '0, 1'b1, 1'b0);

    // irregular random bursts with wrap-around
    for (int b = 0; b < 24; b++) begin
      int len;
      bit mode;
      len  = $urandom_range(1, 8);
      mode = $urandom_range(0, 1) == 1;
      for (int k = 0; k < len; k++) begin
        bit v;
        bit re;
        v  = mode ? 1'b1 : ($urandom_range(0, 3) == 0);
        re = mode ? ($urandom_range(0, 3) == 0) : 1'b1;
        if (q.size() == 0) re = 1'b0;
        cycle(v, 16'($urandom), re, 1'b0);
      end
    end

    // underrun
    while (q.size() != 0) cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b1);
    cycle(1'b0, '0, 1'b0, 1'b0);
`ifdef HW_FEEDER_UNDERRUN_CHECK_EN
    chk("underrun_sticky", 32'(underrun), 32'd1);
`else
    chk("underrun_tied", 32'(underrun), 32'd0);
`endif

    // flush mid-frame
    for (int i = 0; i < 12; i++) cycle(1'b1, 16'(100 + i), 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b1, 16'h0055, 1'b0, 1'b1);
    chk("flush_level", 32'(level), 32'd0);
    for (int i = 0; i < 10; i++) cycle(1'b1, 16'(200 + i), 1'b0, 1'b0);
    fd_seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (frame_done) fd_seen++;
      cycle(1'b0, '0, 1'b1, 1'b0);
    end
    for (int i = 0; i < 3; i++) begin
      if (frame_done) fd_seen++;
      cycle(1'b0, '0, 1'b0, 1'b0);
    end
    chk("flush_fd_count", 32'(fd_seen), 32'd1);
    chk("flush_residual", 32'(level), 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
